prf_multi_read: RTL and testbench

PRF_MULTI_READ -- requirements
Module: prf_multi_read

---
 rtl/prf_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 41 ++++
 rtl/prf_multi_read.sv | 164 ++++++++++++++++
 tb/tb_prf_multi_read.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prf_pkg.sv
// Shared constants and helpers for the physical register file read arbiter.
package prf_pkg;

    localparam int DEF_REG_ADDR_WIDTH = 6;
    localparam int DEF_REG_DATA_WIDTH = 64;
    localparam int NUM_RD_CH          = 6;
    localparam int CH_IDX_W           = 3;

    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    // Channel index addition modulo NUM_RD_CH; both operands expected in 0..5.
    function automatic ch_idx_t ch_add(input ch_idx_t a, input ch_idx_t b);
        logic [CH_IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (CH_IDX_W+1)'(NUM_RD_CH)) begin
            s = s - (CH_IDX_W+1)'(NUM_RD_CH);
        end
        return s[CH_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Round-robin selection of up to two requesters, scanning from ptr upward with wrap.
module rr_pick2
    import prf_pkg::*;
(
    input  logic [NUM_RD_CH-1:0] req,
    input  ch_idx_t              ptr,
    output logic [NUM_RD_CH-1:0] gnt_first,
    output logic [NUM_RD_CH-1:0] gnt_second,
    output logic                 vld_first,
    output logic                 vld_second,
    output ch_idx_t              idx_first,
    output ch_idx_t              idx_second
);

    // Walk the six slots starting at ptr; first two requesters found win.
    always_comb begin
        ch_idx_t idx;
        idx        = '0;
        vld_first  = 1'b0;
        vld_second = 1'b0;
        idx_first  = '0;
        idx_second = '0;
        gnt_first  = '0;
        gnt_second = '0;
        for (int k = 0; k < NUM_RD_CH; k++) begin
            idx = ch_add(ptr, ch_idx_t'(k));
            if (req[idx]) begin
                if (!vld_first) begin
                    vld_first = 1'b1;
                    idx_first = idx;
                end else if (!vld_second) begin
                    vld_second = 1'b1;
                    idx_second = idx;
                end
            end
        end
        if (vld_first)  gnt_first[idx_first]   = 1'b1;
        if (vld_second) gnt_second[idx_second] = 1'b1;
    end

endmodule

// File: rtl/prf_multi_read.sv
// Six-channel read arbiter in front of a two-read-port physical register file,
// with write bypass and registered per-channel responses.
module prf_multi_read
    import prf_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,

    input  logic                      rd1_req_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rd1_address,
    output logic                      rd1_req_ready,
    output logic                      rd1_resp_valid,
    output logic [REG_DATA_WIDTH-1:0] rd1_data,
    input  logic                      rd2_req_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rd2_address,
    output logic                      rd2_req_ready,
    output logic                      rd2_resp_valid,
    output logic [REG_DATA_WIDTH-1:0] rd2_data,
    input  logic                      rd3_req_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rd3_address,
    output logic                      rd3_req_ready,
    output logic                      rd3_resp_valid,
    output logic [REG_DATA_WIDTH-1:0] rd3_data,
    input  logic                      rd4_req_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rd4_address,
    output logic                      rd4_req_ready,
    output logic                      rd4_resp_valid,
    output logic [REG_DATA_WIDTH-1:0] rd4_data,
    input  logic                      rd5_req_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rd5_address,
    output logic                      rd5_req_ready,
    output logic                      rd5_resp_valid,
    output logic [REG_DATA_WIDTH-1:0] rd5_data,
    input  logic                      rd6_req_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rd6_address,
    output logic                      rd6_req_ready,
    output logic                      rd6_resp_valid,
    output logic [REG_DATA_WIDTH-1:0] rd6_data,

    output logic [REG_ADDR_WIDTH-1:0] prf_rd_first_address,
    output logic [REG_ADDR_WIDTH-1:0] prf_rd_second_address,
    input  logic [REG_DATA_WIDTH-1:0] prf_rd_first_data,
    input  logic [REG_DATA_WIDTH-1:0] prf_rd_second_data,

    input  logic                      wr_first_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wr_first_address,
    input  logic [REG_DATA_WIDTH-1:0] wr_first_data,
    input  logic                      wr_second_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wr_second_address,
    input  logic [REG_DATA_WIDTH-1:0] wr_second_data
);

    logic [NUM_RD_CH-1:0]      req_valid;
    logic [REG_ADDR_WIDTH-1:0] req_addr [NUM_RD_CH];

    logic [NUM_RD_CH-1:0]      gnt_first, gnt_second, gnt_live;
    logic                      vld_first, vld_second;
    ch_idx_t                   idx_first, idx_second;
    logic                      live;

    ch_idx_t                   ptr_q, ptr_d;
    logic [NUM_RD_CH-1:0]      resp_valid_q, resp_valid_d;
    logic [REG_DATA_WIDTH-1:0] data_q [NUM_RD_CH];
    logic [REG_DATA_WIDTH-1:0] data_d [NUM_RD_CH];
    logic [REG_DATA_WIDTH-1:0] first_val, second_val;

    assign req_valid = {rd6_req_valid, rd5_req_valid, rd4_req_valid,
                        rd3_req_valid, rd2_req_valid, rd1_req_valid};
    assign req_addr[0] = rd1_address;
    assign req_addr[1] = rd2_address;
    assign req_addr[2] = rd3_address;
    assign req_addr[3] = rd4_address;
    assign req_addr[4] = rd5_address;
    assign req_addr[5] = rd6_address;

    // Grants are only real outside reset and flush.
    assign live = rstn & ~flush;

    rr_pick2 u_pick (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_first  (gnt_first),
        .gnt_second (gnt_second),
        .vld_first  (vld_first),
        .vld_second (vld_second),
        .idx_first  (idx_first),
        .idx_second (idx_second)
    );

    assign gnt_live = (gnt_first | gnt_second) & {NUM_RD_CH{live}};

    assign prf_rd_first_address  = (live && vld_first)  ? req_addr[idx_first]  : '0;
    assign prf_rd_second_address = (live && vld_second) ? req_addr[idx_second] : '0;

    // Newest write wins: second write port over first, over the regfile; index 0 reads zero.
    function automatic logic [REG_DATA_WIDTH-1:0] resolve(
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic [REG_DATA_WIDTH-1:0] rf_data
    );
        if (addr == '0)                                    return '0;
        else if (wr_second_valid && wr_second_address == addr) return wr_second_data;
        else if (wr_first_valid && wr_first_address == addr)   return wr_first_data;
        else                                               return rf_data;
    endfunction

    assign first_val  = resolve(prf_rd_first_address, prf_rd_first_data);
    assign second_val = resolve(prf_rd_second_address, prf_rd_second_data);

    // Next pointer, response pulses and captured data for granted channels.
    always_comb begin
        ptr_d        = ptr_q;
        resp_valid_d = gnt_live;
        data_d       = data_q;
        if (live) begin
            if (vld_second)     ptr_d = ch_add(idx_second, ch_idx_t'(1));
            else if (vld_first) ptr_d = ch_add(idx_first, ch_idx_t'(1));
        end
        for (int i = 0; i < NUM_RD_CH; i++) begin
            if (live && vld_first && idx_first == ch_idx_t'(i)) begin
                data_d[i] = first_val;
            end else if (live && vld_second && idx_second == ch_idx_t'(i)) begin
                data_d[i] = second_val;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q        <= '0;
            resp_valid_q <= '0;
            for (int i = 0; i < NUM_RD_CH; i++) data_q[i] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            for (int i = 0; i < NUM_RD_CH; i++) data_q[i] <= data_d[i];
        end
    end

    // A flush also squashes a response already in flight.
    assign rd1_req_ready  = gnt_live[0];
    assign rd2_req_ready  = gnt_live[1];
    assign rd3_req_ready  = gnt_live[2];
    assign rd4_req_ready  = gnt_live[3];
    assign rd5_req_ready  = gnt_live[4];
    assign rd6_req_ready  = gnt_live[5];
    assign rd1_resp_valid = resp_valid_q[0] & ~flush;
    assign rd2_resp_valid = resp_valid_q[1] & ~flush;
    assign rd3_resp_valid = resp_valid_q[2] & ~flush;
    assign rd4_resp_valid = resp_valid_q[3] & ~flush;
    assign rd5_resp_valid = resp_valid_q[4] & ~flush;
    assign rd6_resp_valid = resp_valid_q[5] & ~flush;
    assign rd1_data       = data_q[0];
    assign rd2_data       = data_q[1];
    assign rd3_data       = data_q[2];
    assign rd4_data       = data_q[3];
    assign rd5_data       = data_q[4];
    assign rd6_data       = data_q[5];

endmodule

// File: tb/tb_prf_multi_read.sv
// Bench for prf_multi_read: directed scenarios plus a randomized run against a reference model.
module tb_prf_multi_read;

    logic        clk = 1'b0;
    logic        rstn, flush;
    logic [5:0]  v, rdy, rv;
    logic [5:0]  a   [6];
    logic [63:0] dat [6];
    logic [5:0]  pa1, pa2;
    logic [63:0] pd1, pd2;
    logic        w1v, w2v;
    logic [5:0]  w1a, w2a;
    logic [63:0] w1d, w2d;
    logic [63:0] rf [64];

    int total = 0;
    int bad   = 0;

    int          ptr_m;
    logic [5:0]  pend_m;
    logic [63:0] dm [6];

    always #5 clk = ~clk;

    assign pd1 = rf[pa1];
    assign pd2 = rf[pa2];

    prf_multi_read dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .rd1_req_valid(v[0]), .rd1_address(a[0]), .rd1_req_ready(rdy[0]), .rd1_resp_valid(rv[0]), .rd1_data(dat[0]),
        .rd2_req_valid(v[1]), .rd2_address(a[1]), .rd2_req_ready(rdy[1]), .rd2_resp_valid(rv[1]), .rd2_data(dat[1]),
        .rd3_req_valid(v[2]), .rd3_address(a[2]), .rd3_req_ready(rdy[2]), .rd3_resp_valid(rv[2]), .rd3_data(dat[2]),
        .rd4_req_valid(v[3]), .rd4_address(a[3]), .rd4_req_ready(rdy[3]), .rd4_resp_valid(rv[3]), .rd4_data(dat[3]),
        .rd5_req_valid(v[4]), .rd5_address(a[4]), .rd5_req_ready(rdy[4]), .rd5_resp_valid(rv[4]), .rd5_data(dat[4]),
        .rd6_req_valid(v[5]), .rd6_address(a[5]), .rd6_req_ready(rdy[5]), .rd6_resp_valid(rv[5]), .rd6_data(dat[5]),
        .prf_rd_first_address(pa1), .prf_rd_second_address(pa2),
        .prf_rd_first_data(pd1), .prf_rd_second_data(pd2),
        .wr_first_valid(w1v), .wr_first_address(w1a), .wr_first_data(w1d),
        .wr_second_valid(w2v), .wr_second_address(w2a), .wr_second_data(w2d)
    );

    // Reference: first two valid channels in order ptr, ptr+1, ... mod 6.
    task automatic model_pick(output int g0, output int g1);
        g0 = -1;
        g1 = -1;
        for (int k = 0; k < 6; k++) begin
            int idx;
            idx = (ptr_m + k) % 6;
            if (v[idx]) begin
                if (g0 < 0)      g0 = idx;
                else if (g1 < 0) g1 = idx;
            end
        end
    endtask

    function automatic logic [63:0] ref_val(input logic [5:0] ad);
        if (ad == 0)                 return 64'd0;
        if (w2v && w2a == ad)        return w2d;
        if (w1v && w1a == ad)        return w1d;
        return rf[ad];
    endfunction

    // Advance the reference model across one clock edge using the current inputs.
    task automatic model_step();
        int g0, g1;
        model_pick(g0, g1);
        if (!rstn) begin
            ptr_m  = 0;
            pend_m = '0;
            for (int i = 0; i < 6; i++) dm[i] = 64'd0;
        end else if (flush) begin
            pend_m = '0;
        end else begin
            pend_m = '0;
            if (g0 >= 0) begin pend_m[g0] = 1'b1; dm[g0] = ref_val(a[g0]); end
            if (g1 >= 0) begin pend_m[g1] = 1'b1; dm[g1] = ref_val(a[g1]); end
            if (g1 >= 0)      ptr_m = (g1 + 1) % 6;
            else if (g0 >= 0) ptr_m = (g0 + 1) % 6;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 1'b0;
        v     = '0;
        w1v   = 1'b0; w1a = '0; w1d = '0;
        w2v   = 1'b0; w2a = '0; w2d = '0;
        for (int i = 0; i < 6; i++) a[i] = 6'(i + 1);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        v = 6'h3f;
        #1;
        total++;
        if (rdy !== 6'h00) begin bad++; $display("FAIL reset_ready got=%b exp=%b", rdy, 6'h00); end
        tick();
        tick();
        total++;
        if (rv !== 6'h00) begin bad++; $display("FAIL reset_resp_valid got=%b exp=%b", rv, 6'h00); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (dat[i] !== 64'd0) begin bad++; $display("FAIL reset_data ch%0d got=%h exp=0", i + 1, dat[i]); end
        end
        rstn = 1'b1;
        clear_inputs();
    endtask

    task automatic test_basic();
        rf[5] = 64'hA;
        rf[9] = 64'hB;
        v[0] = 1'b1; a[0] = 6'd5;
        v[3] = 1'b1; a[3] = 6'd9;
        #1;
        total++;
        if (rdy !== 6'b001001) begin bad++; $display("FAIL basic_ready got=%b exp=%b", rdy, 6'b001001); end
        total++;
        if (pa1 !== 6'd5 || pa2 !== 6'd9) begin bad++; $display("FAIL basic_ports got=%0d,%0d exp=5,9", pa1, pa2); end
        tick();
        clear_inputs();
        #1;
        total++;
        if (rv !== 6'b001001) begin bad++; $display("FAIL basic_resp_valid got=%b exp=%b", rv, 6'b001001); end
        total++;
        if (dat[0] !== 64'hA || dat[3] !== 64'hB) begin bad++; $display("FAIL basic_data got=%h,%h exp=a,b", dat[0], dat[3]); end
        v = 6'h3f;
        #1;
        total++;
        if (rdy !== 6'b110000) begin bad++; $display("FAIL basic_ptr4 got=%b exp=%b", rdy, 6'b110000); end
        tick();
        clear_inputs();
        #1;
        total++;
        if (rv !== 6'b110000) begin bad++; $display("FAIL basic_pulse got=%b exp=%b", rv, 6'b110000); end
        tick();
        total++;
        if (rv !== 6'b000000) begin bad++; $display("FAIL basic_pulse_end got=%b exp=0", rv); end
    endtask

    task automatic test_all_valid();
        logic [5:0] exp_g [4];
        exp_g[0] = 6'b000011; exp_g[1] = 6'b001100;
        exp_g[2] = 6'b110000; exp_g[3] = 6'b000011;
        v = 6'h3f;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (rdy !== exp_g[c]) begin bad++; $display("FAIL all_valid_grant c%0d got=%b exp=%b", c, rdy, exp_g[c]); end
            if (c > 0) begin
                total++;
                if (rv !== exp_g[c-1]) begin bad++; $display("FAIL all_valid_resp c%0d got=%b exp=%b", c, rv, exp_g[c-1]); end
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_wrap();
        v[4] = 1'b1;
        tick();
        clear_inputs();
        v[5] = 1'b1; a[5] = 6'd3;
        v[0] = 1'b1; a[0] = 6'd4;
        #1;
        total++;
        if (rdy !== 6'b100001) begin bad++; $display("FAIL wrap_ready got=%b exp=%b", rdy, 6'b100001); end
        total++;
        if (pa1 !== 6'd3 || pa2 !== 6'd4) begin bad++; $display("FAIL wrap_ports got=%0d,%0d exp=3,4", pa1, pa2); end
        tick();
        clear_inputs();
        v = 6'h3f;
        #1;
        total++;
        if (rdy !== 6'b000110) begin bad++; $display("FAIL wrap_next_ptr got=%b exp=%b", rdy, 6'b000110); end
        total++;
        if (dat[5] !== rf[3] || dat[0] !== rf[4]) begin bad++; $display("FAIL wrap_data got=%h,%h exp=%h,%h", dat[5], dat[0], rf[3], rf[4]); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_bypass();
        logic        c_w1v [5];
        logic        c_w2v [5];
        logic [5:0]  c_w1a [5];
        logic [5:0]  c_w2a [5];
        logic [5:0]  c_ra  [5];
        logic [63:0] c_exp [5];
        rf[7] = 64'h0123_4567_89ab_cdef;
        rf[0] = 64'hdead_beef;
        c_w1v[0] = 1; c_w1a[0] = 7; c_w2v[0] = 1; c_w2a[0] = 7; c_ra[0] = 7; c_exp[0] = 64'h22;
        c_w1v[1] = 1; c_w1a[1] = 7; c_w2v[1] = 0; c_w2a[1] = 7; c_ra[1] = 7; c_exp[1] = 64'h11;
        c_w1v[2] = 1; c_w1a[2] = 0; c_w2v[2] = 1; c_w2a[2] = 0; c_ra[2] = 0; c_exp[2] = 64'h0;
        c_w1v[3] = 1; c_w1a[3] = 8; c_w2v[3] = 1; c_w2a[3] = 9; c_ra[3] = 7; c_exp[3] = rf[7];
        c_w1v[4] = 0; c_w1a[4] = 7; c_w2v[4] = 1; c_w2a[4] = 7; c_ra[4] = 7; c_exp[4] = 64'h22;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            v[1] = 1'b1; a[1] = c_ra[c];
            w1v = c_w1v[c]; w1a = c_w1a[c]; w1d = 64'h11;
            w2v = c_w2v[c]; w2a = c_w2a[c]; w2d = 64'h22;
            tick();
            clear_inputs();
            #1;
            total++;
            if (rv[1] !== 1'b1 || dat[1] !== c_exp[c]) begin
                bad++;
                $display("FAIL bypass c%0d got valid=%b data=%h exp valid=1 data=%h", c, rv[1], dat[1], c_exp[c]);
            end
        end
        tick();
    endtask

    task automatic test_flush();
        clear_inputs();
        v[2] = 1'b1; a[2] = 6'd5;
        #1;
        total++;
        if (rdy[2] !== 1'b1) begin bad++; $display("FAIL flush_pre_grant got=%b exp=1", rdy[2]); end
        tick();
        flush = 1'b1;
        #1;
        total++;
        if (rdy !== 6'h00) begin bad++; $display("FAIL flush_ready got=%b exp=0", rdy); end
        total++;
        if (rv !== 6'h00) begin bad++; $display("FAIL flush_resp_t1 got=%b exp=0", rv); end
        total++;
        if (pa1 !== 6'd0 || pa2 !== 6'd0) begin bad++; $display("FAIL flush_ports got=%0d,%0d exp=0,0", pa1, pa2); end
        tick();
        clear_inputs();
        #1;
        total++;
        if (rv !== 6'h00) begin bad++; $display("FAIL flush_resp_t2 got=%b exp=0", rv); end
        tick();
    endtask

    task automatic test_reset_mid();
        v = 6'h3f;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 6; i++) a[i] = 6'($urandom_range(1, 63));
            tick();
        end
        rstn = 1'b0;
        #1;
        total++;
        if (rdy !== 6'h00) begin bad++; $display("FAIL midreset_ready got=%b exp=0", rdy); end
        tick();
        rstn = 1'b1;
        #1;
        total++;
        if (rv !== 6'h00) begin bad++; $display("FAIL midreset_resp got=%b exp=0", rv); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (dat[i] !== 64'd0) begin bad++; $display("FAIL midreset_data ch%0d got=%h exp=0", i + 1, dat[i]); end
        end
        total++;
        if (rdy !== 6'b000011) begin bad++; $display("FAIL midreset_first_grant got=%b exp=%b", rdy, 6'b000011); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int         g0, g1;
            logic       lv;
            logic [5:0] exp_rdy, exp_a1, exp_a2;
            rstn  = ($urandom_range(0, 19) != 0);
            flush = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 6; i++) begin
                v[i] = ($urandom_range(0, 9) < 6);
                a[i] = 6'($urandom_range(0, 15));
            end
            w1v = $urandom_range(0, 1); w1a = 6'($urandom_range(0, 15)); w1d = {$urandom, $urandom};
            w2v = $urandom_range(0, 1); w2a = 6'($urandom_range(0, 15)); w2d = {$urandom, $urandom};
            #1;
            model_pick(g0, g1);
            lv      = rstn && !flush;
            exp_rdy = '0;
            exp_a1  = '0;
            exp_a2  = '0;
            if (lv && g0 >= 0) begin exp_rdy[g0] = 1'b1; exp_a1 = a[g0]; end
            if (lv && g1 >= 0) begin exp_rdy[g1] = 1'b1; exp_a2 = a[g1]; end
            total++;
            if (rdy !== exp_rdy) begin bad++; $display("FAIL rand_ready c%0d got=%b exp=%b", c, rdy, exp_rdy); end
            total++;
            if (pa1 !== exp_a1 || pa2 !== exp_a2) begin bad++; $display("FAIL rand_ports c%0d got=%0d,%0d exp=%0d,%0d", c, pa1, pa2, exp_a1, exp_a2); end
            total++;
            if (rv !== (flush ? 6'h00 : pend_m)) begin bad++; $display("FAIL rand_resp c%0d got=%b exp=%b", c, rv, flush ? 6'h00 : pend_m); end
            for (int i = 0; i < 6; i++) begin
                total++;
                if (dat[i] !== dm[i]) begin bad++; $display("FAIL rand_data c%0d ch%0d got=%h exp=%h", c, i + 1, dat[i], dm[i]); end
            end
            tick();
        end
        rstn = 1'b1;
        clear_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rf[i] = {$urandom, $urandom};
        ptr_m  = 0;
        pend_m = '0;
        for (int i = 0; i < 6; i++) dm[i] = 64'd0;
        test_reset();
        test_basic();
        test_all_valid();
        test_wrap();
        test_bypass();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
